store_merge: RTL and testbench

STORE_MERGE -- requirements
Module: store_merge

---
 rtl/store_merge.sv | 142 ++++++++++++++
 tb/tb_store_merge.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/store_merge.sv
// Sub-word store engine: merges a byte/halfword into a read-back memory word and writes it.
// Latency: word store writes in the cycle after Start; byte/halfword reads next, then writes two cycles later.
// No backpressure: memory is assumed always ready, and Start is ignored while busy.
// Optional feature: define STORE_MERGE_ALIGN_CHECK_EN to reject misaligned halfword/word requests.
module store_merge (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic        addr_error,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_read_data,
  output logic        mem_write,
  output logic [31:0] mem_write_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3
`ifdef STORE_MERGE_ALIGN_CHECK_EN
    ,
    ERR   = 3'd4
`endif
  } state_t;

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [15:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] merged;
  logic        sub_word;
  logic        misaligned;

  // Halfword and byte stores need the old word; word stores (00 and 11) do not.
  assign sub_word = (size == SZ_HALF) || (size == SZ_BYTE);

`ifdef STORE_MERGE_ALIGN_CHECK_EN
  // Byte stores are always aligned; halfwords need Addr[0]=0, words need Addr[1:0]=0.
  assign misaligned = ((size == SZ_HALF) && addr[0]) ||
                      (!sub_word && (addr[1:0] != 2'b00));
`else
  // Without the check, low address bits are simply ignored where they would misalign.
  assign misaligned = 1'b0;
`endif

  // Next-state decode; requests are only taken in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (misaligned) begin
`ifdef STORE_MERGE_ALIGN_CHECK_EN
            state_d = ERR;
`else
            state_d = IDLE;
`endif
          end else if (sub_word) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ:    state_d = WAIT;
      WAIT:    state_d = WRITE;
      WRITE:   state_d = IDLE;
`ifdef STORE_MERGE_ALIGN_CHECK_EN
      ERR:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset aborts any store in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lane merge of the payload into the word returned by memory (little-endian lanes).
  always_comb begin
    merged = mem_read_data;
    if (size_q == SZ_HALF) begin
      // Halfword offset is {Addr[1],0}; Addr[0] never selects a lane.
      if (addr_q[1]) begin
        merged[31:16] = wdata_q[15:0];
      end else begin
        merged[15:0] = wdata_q[15:0];
      end
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Request latches: captured at Start, merge register reloaded with the merged word in WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      addr_q  <= addr;
      size_q  <= size;
      wdata_q <= write_data[15:0];
      merge_q <= write_data;
    end else if (state_q == WAIT) begin
      merge_q <= merged;
    end
  end

  // Moore outputs: strobes from state, data from registers only.
  assign busy           = (state_q != IDLE);
  assign mem_read       = (state_q == READ);
  assign mem_write      = (state_q == WRITE);
  assign mem_addr       = {addr_q[31:2], 2'b00};
  assign mem_write_data = merge_q;
`ifdef STORE_MERGE_ALIGN_CHECK_EN
  assign addr_error     = (state_q == ERR);
  assign done           = (state_q == WRITE) || (state_q == ERR);
`else
  assign addr_error     = 1'b0;
  assign done           = (state_q == WRITE);
`endif

endmodule

// File: tb/tb_store_merge.sv
// Directed bench for store_merge: word/halfword/byte merges, alignment handling, reset abort, busy Start.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Memory model is a directed read-data value presented only during the WAIT cycle.
module tb_store_merge;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        addr_error;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_read_data;
  logic        mem_write;
  logic [31:0] mem_write_data;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] JUNK = 32'h5A5A0F0F;

  store_merge dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .size           (size),
    .addr           (addr),
    .write_data     (write_data),
    .busy           (busy),
    .done           (done),
    .addr_error     (addr_error),
    .mem_addr       (mem_addr),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one accepted store from IDLE and checks every cycle through the return to IDLE.
  task automatic do_store(input string nm, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input logic [31:0] ea, input logic [31:0] ed);
    logic sub;
    sub = (sz == 2'b01) || (sz == 2'b10);
    start = 1'b1; size = sz; addr = a; write_data = wd; mem_read_data = JUNK;
    step();
    // Scramble the inputs: the operation in flight must not notice.
    start = 1'b0; size = ~sz; addr = ~a; write_data = ~wd;
    if (!sub) begin
      chk({nm, "_n1_wr"},   {31'd0, mem_write}, 32'd1);
      chk({nm, "_n1_done"}, {31'd0, done},      32'd1);
      chk({nm, "_n1_rd"},   {31'd0, mem_read},  32'd0);
      chk({nm, "_n1_aerr"}, {31'd0, addr_error}, 32'd0);
      chk({nm, "_addr"},    mem_addr,           ea);
      chk({nm, "_data"},    mem_write_data,     ed);
    end else begin
      chk({nm, "_n1_rd"},   {31'd0, mem_read},  32'd1);
      chk({nm, "_n1_wr"},   {31'd0, mem_write}, 32'd0);
      chk({nm, "_n1_done"}, {31'd0, done},      32'd0);
      chk({nm, "_n1_busy"}, {31'd0, busy},      32'd1);
      chk({nm, "_n1_addr"}, mem_addr,           ea);
      step();
      chk({nm, "_n2_rdwr"}, {30'd0, mem_read, mem_write}, 32'd0);
      chk({nm, "_n2_done"}, {31'd0, done},      32'd0);
      chk({nm, "_n2_addr"}, mem_addr,           ea);
      mem_read_data = rd;
      step();
      mem_read_data = JUNK;
      chk({nm, "_n3_wr"},   {31'd0, mem_write}, 32'd1);
      chk({nm, "_n3_done"}, {31'd0, done},      32'd1);
      chk({nm, "_n3_rd"},   {31'd0, mem_read},  32'd0);
      chk({nm, "_addr"},    mem_addr,           ea);
      chk({nm, "_data"},    mem_write_data,     ed);
    end
    step();
    chk({nm, "_idle"}, {29'd0, busy, done, mem_write}, 32'd0);
  endtask

`ifdef STORE_MERGE_ALIGN_CHECK_EN
  // Rejected request: ERR in N+1 with no strobes, then IDLE.
  task automatic do_err(input string nm, input logic [1:0] sz, input logic [31:0] a);
    start = 1'b1; size = sz; addr = a; write_data = 32'h13572468;
    step();
    start = 1'b0;
    chk({nm, "_aerr"},  {31'd0, addr_error}, 32'd1);
    chk({nm, "_done"},  {31'd0, done},       32'd1);
    chk({nm, "_strb"},  {30'd0, mem_read, mem_write}, 32'd0);
    chk({nm, "_busy"},  {31'd0, busy},       32'd1);
    step();
    chk({nm, "_idle"},  {29'd0, busy, done, addr_error}, 32'd0);
  endtask
`endif

  initial begin
    int done_cnt;
    reset = 1'b0; start = 1'b0; size = 2'b00; addr = '0; write_data = '0; mem_read_data = JUNK;
    step();
    step();
    chk("rst_ctrl", {27'd0, busy, done, addr_error, mem_read, mem_write}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_write_data, 32'd0);
    reset = 1'b1;
    step();

    // Main directed vectors; each begins in the IDLE cycle after the previous Done (back-to-back).
    do_store("word",   2'b00, 32'h0000_0100, 32'hDEADBEEF, JUNK,         32'h0000_0100, 32'hDEADBEEF);
    do_store("byte3",  2'b10, 32'h0000_0203, 32'h0000_00A5, 32'h11223344, 32'h0000_0200, 32'hA5223344);
    do_store("half2",  2'b01, 32'h0000_0042, 32'hFFFF1234, 32'hAABBCCDD, 32'h0000_0040, 32'h1234CCDD);
    do_store("half0",  2'b01, 32'h0000_0044, 32'h0000BEEF, 32'h11223344, 32'h0000_0044, 32'h1122BEEF);
    do_store("byte0",  2'b10, 32'h0000_0300, 32'h0000_0077, 32'h11223344, 32'h0000_0300, 32'h11223377);
    do_store("byte1",  2'b10, 32'h0000_0301, 32'hFFFFFF5A, 32'h11223344, 32'h0000_0300, 32'h11225A44);
    do_store("byte2",  2'b10, 32'h8000_0302, 32'h000000C3, 32'h11223344, 32'h8000_0300, 32'h11C33344);
    do_store("size11", 2'b11, 32'h0000_0208, 32'h01234567, JUNK,         32'h0000_0208, 32'h01234567);

`ifdef STORE_MERGE_ALIGN_CHECK_EN
    do_err("mis_half1", 2'b01, 32'h0000_0001);
    do_err("mis_half3", 2'b01, 32'h0000_0003);
    do_err("mis_word2", 2'b00, 32'h0000_0102);
`else
    do_store("mis_half1", 2'b01, 32'h0000_0001, 32'h00005678, 32'hAABBCCDD, 32'h0000_0000, 32'hAABB5678);
    do_store("mis_half3", 2'b01, 32'h0000_0003, 32'h00009ABC, 32'hAABBCCDD, 32'h0000_0000, 32'h9ABCCCDD);
    do_store("mis_word2", 2'b00, 32'h0000_0102, 32'hCAFEBABE, JUNK,         32'h0000_0100, 32'hCAFEBABE);
`endif

    // Start held during Busy: the original byte store completes alone, exactly one Done.
    done_cnt = 0;
    start = 1'b1; size = 2'b10; addr = 32'h0000_0105; write_data = 32'h00000099; mem_read_data = JUNK;
    step();
    size = 2'b00; addr = 32'h0000_0400; write_data = 32'hCAFEF00D;
    if (done) done_cnt++;
    step();
    mem_read_data = 32'h11223344;
    if (done) done_cnt++;
    step();
    start = 1'b0; mem_read_data = JUNK;
    chk("bsy_addr", mem_addr, 32'h0000_0104);
    chk("bsy_data", mem_write_data, 32'h11229944);
    for (int i = 0; i < 5; i++) begin
      if (done) done_cnt++;
      step();
    end
    chk("bsy_done_cnt", done_cnt, 32'd1);
    chk("bsy_idle", {31'd0, busy}, 32'd0);

    // Reset in the WAIT cycle aborts the byte store with no write.
    start = 1'b1; size = 2'b10; addr = 32'h0000_0203; write_data = 32'h000000A5;
    step();
    start = 1'b0;
    step();
    reset = 1'b0; mem_read_data = 32'h11223344;
    step();
    chk("abort_ctrl", {29'd0, busy, done, mem_write}, 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    chk("abort_data", mem_write_data, 32'd0);
    reset = 1'b1;
    step();
    chk("abort_late", {29'd0, busy, done, mem_write}, 32'd0);
    do_store("post_abort", 2'b10, 32'h0000_0203, 32'h000000A5, 32'h11223344, 32'h0000_0200, 32'hA5223344);

    // Reset wins over a simultaneous Start.
    reset = 1'b0; start = 1'b1; size = 2'b00; addr = 32'h0000_0500; write_data = 32'h0F0F0F0F;
    step();
    chk("rst_prio", {29'd0, busy, done, mem_write}, 32'd0);
    chk("rst_prio_addr", mem_addr, 32'd0);
    reset = 1'b1; start = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
